// File: rtl/ocimem_debug_ram_ctrl_if.sv
// CPU-side Avalon-MM bundle for the on-chip debug RAM.
// The master drives requests and the slave returns read data and the stall.
interface ocimem_debug_ram_ctrl_if #(
    parameter int ADDR_W = 8
) ();
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/ocimem_debug_ram_ctrl.sv
// Debug RAM controller: JTAG command port (MonAReg/MonDReg) and a CPU Avalon-MM port
// sharing one single-port synchronous RAM, with JTAG always taking priority.
module ocimem_debug_ram_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [37:0]             jdo,
    input  logic                    take_action_ocimem_a,
    input  logic                    take_action_ocimem_b,
    input  logic                    take_no_action_ocimem_a,
    ocimem_debug_ram_ctrl_if.slave  avs,
    output logic [31:0]             MonDReg,
    output logic [ADDR_W-1:0]       MonAReg,
    output logic                    cmd_overflow
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {S_IDLE, S_JRD, S_CRD} state_e;
    typedef enum logic [1:0] {CMD_NONE, CMD_A, CMD_B, CMD_NA} cmd_e;

    state_e            state_q;
    logic              rst_done_q;
    logic              crd_valid_q;
    logic              ovf_q;
    logic [ADDR_W-1:0] mon_a_q;
    logic [31:0]       mon_d_q;
    logic [31:0]       rdata_q;

    logic              pend_valid_q;
    cmd_e              pend_cmd_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [31:0]       pend_data_q;
    logic              pend_rd_q;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q;

    cmd_e              live_cmd;
    cmd_e              srv_cmd;
    logic              live_loss;
    logic [ADDR_W-1:0] jdo_addr;
    logic [ADDR_W-1:0] srv_addr;
    logic [ADDR_W-1:0] mon_a_inc;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       jdo_data;
    logic [31:0]       srv_data;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic              jdo_rd;
    logic              srv_rd;
    logic              cpu_ok;
    logic              ram_we;
    logic              ram_re;
    logic              wait_c;

    // jdo framing bits outside the address/rd/data fields carry nothing for this block.
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    assign jdo_addr  = jdo[26 +: ADDR_W];
    assign jdo_rd    = jdo[25];
    assign jdo_data  = jdo[34:3];
    assign mon_a_inc = mon_a_q + ADDR_W'(1);

    assign live_loss = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                     | (take_action_ocimem_b & take_no_action_ocimem_a);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        live_cmd = CMD_NONE;
        if (take_action_ocimem_a)         live_cmd = CMD_A;
        else if (take_action_ocimem_b)    live_cmd = CMD_B;
        else if (take_no_action_ocimem_a) live_cmd = CMD_NA;
    end

    // A pending command is older than any live pulse, so it is served first.
    always_comb begin
        srv_cmd  = CMD_NONE;
        srv_addr = jdo_addr;
        srv_data = jdo_data;
        srv_rd   = jdo_rd;
        if (state_q == S_IDLE) begin
            if (pend_valid_q) begin
                srv_cmd  = pend_cmd_q;
                srv_addr = pend_addr_q;
                srv_data = pend_data_q;
                srv_rd   = pend_rd_q;
            end else begin
                srv_cmd = live_cmd;
            end
        end
    end

    assign cpu_ok = (state_q == S_IDLE) && (srv_cmd == CMD_NONE) && rst_done_q;

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_be    = 4'h0;
        ram_addr  = mon_a_q;
        ram_wdata = srv_data;
        wait_c    = 1'b1;
        case (srv_cmd)
            CMD_A: begin
                ram_re   = srv_rd;
                ram_addr = srv_addr;
            end
            CMD_B: begin
                ram_we = 1'b1;
                ram_be = 4'hF;
            end
            CMD_NA: begin
                ram_re   = 1'b1;
                ram_addr = mon_a_inc;
            end
            CMD_NONE: begin
                if (cpu_ok && avs.avs_read) begin
                    ram_re   = 1'b1;
                    ram_addr = avs.avs_address;
                end else if (cpu_ok && avs.avs_write) begin
                    ram_we    = 1'b1;
                    ram_be    = avs.avs_byteenable;
                    ram_addr  = avs.avs_address;
                    ram_wdata = avs.avs_writedata;
                    wait_c    = 1'b0;
                end
            end
        endcase
        if (state_q == S_CRD && crd_valid_q) wait_c = 1'b0;
    end

    // NOTE: the RAM array has no reset; only the control registers below are reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
            end
        end
        if (ram_re) ram_q <= mem[ram_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            rst_done_q   <= 1'b0;
            crd_valid_q  <= 1'b0;
            ovf_q        <= 1'b0;
            mon_a_q      <= '0;
            mon_d_q      <= '0;
            rdata_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_cmd_q   <= CMD_NONE;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            pend_rd_q    <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            if (live_loss) ovf_q <= 1'b1;

            if (state_q == S_IDLE && pend_valid_q) pend_valid_q <= 1'b0;
            if (live_cmd != CMD_NONE) begin
                if (pend_valid_q) begin
                    ovf_q <= 1'b1;
                end else if (state_q != S_IDLE) begin
                    pend_valid_q <= 1'b1;
                    pend_cmd_q   <= live_cmd;
                    pend_addr_q  <= jdo_addr;
                    pend_data_q  <= jdo_data;
                    pend_rd_q    <= jdo_rd;
                end
            end

            case (state_q)
                S_IDLE: begin
                    case (srv_cmd)
                        CMD_A: begin
                            mon_a_q <= srv_addr;
                            if (srv_rd) state_q <= S_JRD;
                        end
                        CMD_B:  mon_a_q <= mon_a_inc;
                        CMD_NA: begin
                            mon_a_q <= mon_a_inc;
                            state_q <= S_JRD;
                        end
                        CMD_NONE: begin
                            if (cpu_ok && avs.avs_read) begin
                                state_q     <= S_CRD;
                                crd_valid_q <= 1'b0;
                            end
                        end
                    endcase
                end
                S_JRD: begin
                    mon_d_q <= ram_q;
                    state_q <= S_IDLE;
                end
                S_CRD: begin
                    // First CRD cycle registers the data; the second one completes the transfer.
                    if (!crd_valid_q) begin
                        rdata_q     <= ram_q;
                        crd_valid_q <= 1'b1;
                    end else begin
                        crd_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign MonDReg             = mon_d_q;
    assign MonAReg             = mon_a_q;
    assign cmd_overflow        = ovf_q;
    assign avs.avs_readdata    = rdata_q;
    assign avs.avs_waitrequest = wait_c;
endmodule

// File: tb/tb_ocimem_debug_ram_ctrl.sv
// Directed and randomized bench for ocimem_debug_ram_ctrl, checked against a
// command-level model of the RAM, MonAReg, MonDReg and the sticky overflow flag.
module tb_ocimem_debug_ram_ctrl;
    localparam int ADDR_W   = 8;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int MAX_WAIT = 20;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              tk_a;
    logic              tk_b;
    logic              tk_na;
    logic [31:0]       mon_d;
    logic [ADDR_W-1:0] mon_a;
    logic              ovf;

    ocimem_debug_ram_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    ocimem_debug_ram_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (tk_a),
        .take_action_ocimem_b    (tk_b),
        .take_no_action_ocimem_a (tk_na),
        .avs                     (bus),
        .MonDReg                 (mon_d),
        .MonAReg                 (mon_a),
        .cmd_overflow            (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [DEPTH];
    int          m_a;
    logic [31:0] m_d;
    bit          m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] a_word(input logic [ADDR_W-1:0] a, input logic rd);
        logic [37:0] w;
        w = '0;
        w[26 +: ADDR_W] = a;
        w[25] = rd;
        return w;
    endfunction

    function automatic logic [37:0] b_word(input logic [31:0] d);
        logic [37:0] w;
        w = '0;
        w[34:3] = d;
        return w;
    endfunction

    // Command semantics: highest-priority pulse wins, the others only raise the overflow flag.
    function automatic void model_jtag(input logic [2:0] mask, input logic [37:0] w);
        if ($countones(mask) > 1) m_ovf = 1'b1;
        if (mask[2]) begin
            m_a = int'(w[26 +: ADDR_W]);
            if (w[25]) m_d = m_mem[m_a];
        end else if (mask[1]) begin
            m_mem[m_a] = w[34:3];
            m_a = (m_a + 1) % DEPTH;
        end else if (mask[0]) begin
            m_a = (m_a + 1) % DEPTH;
            m_d = m_mem[m_a];
        end
    endfunction

    task automatic drive_pulse(input logic [2:0] mask, input logic [37:0] w);
        jdo = w;
        {tk_a, tk_b, tk_na} = mask;
    endtask

    task automatic clear_pulse();
        {tk_a, tk_b, tk_na} = 3'b000;
    endtask

    task automatic jtag_cmd(input string tag, input logic [2:0] mask, input logic [37:0] w,
                            input int gap);
        logic [31:0] old_d;
        old_d = m_d;
        drive_pulse(mask, w);
        tick();
        clear_pulse();
        model_jtag(mask, w);
        check({tag, "_areg"}, 32'(mon_a), 32'(m_a));
        check({tag, "_dhold"}, mon_d, old_d);
        tick();
        check({tag, "_dreg"}, mon_d, m_d);
        check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
        repeat (gap) tick();
    endtask

    task automatic cpu_write(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                             input logic [3:0] be);
        int lat;
        bit done;
        bus.avs_address    = a;
        bus.avs_writedata  = d;
        bus.avs_byteenable = be;
        bus.avs_write      = 1'b1;
        lat  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            lat++;
            if (!bus.avs_waitrequest || lat >= MAX_WAIT) done = 1'b1;
            tick();
        end
        bus.avs_write = 1'b0;
        check({tag, "_lat"}, lat, 1);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    // Optionally injects one JTAG pulse in request cycle jt_at (0 = same cycle as the request).
    task automatic cpu_read(input string tag, input logic [ADDR_W-1:0] a, input int jt_at,
                            input logic [2:0] jt_mask, input logic [37:0] jt_w,
                            input int exp_lat, output logic [31:0] data);
        int lat;
        bit done;
        logic [31:0] exp;
        exp  = m_mem[a];
        data = 'x;
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        lat  = 0;
        done = 1'b0;
        while (!done) begin
            if (lat == jt_at) begin
                drive_pulse(jt_mask, jt_w);
                model_jtag(jt_mask, jt_w);
                if (jt_at == 0) exp = m_mem[a];
            end
            @(negedge clk);
            lat++;
            if (!bus.avs_waitrequest) begin
                data = bus.avs_readdata;
                done = 1'b1;
            end else if (lat >= MAX_WAIT) begin
                done = 1'b1;
            end
            tick();
            clear_pulse();
        end
        bus.avs_read = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, data, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] data;
        logic [63:0] r;
        int op;

        reset_n            = 1'b0;
        jdo                = '0;
        tk_a               = 1'b0;
        tk_b               = 1'b0;
        tk_na              = 1'b0;
        bus.avs_read       = 1'b0;
        bus.avs_write      = 1'b1;
        bus.avs_address    = 8'h30;
        bus.avs_writedata  = 32'h3030_3030;
        bus.avs_byteenable = 4'hF;
        m_a   = 0;
        m_d   = '0;
        m_ovf = 1'b0;

        #3;
        check("rst_dreg", mon_d, 32'h0);
        check("rst_areg", 32'(mon_a), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_rdata", bus.avs_readdata, 32'h0);
        check("rst_wait", 32'(bus.avs_waitrequest), 32'h1);

        // Hold a write across reset release: it must stall only until the first edge.
        @(posedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        check("wait_before_first_edge", 32'(bus.avs_waitrequest), 32'h1);
        @(negedge clk);
        check("wait_after_first_edge", 32'(bus.avs_waitrequest), 32'h0);
        tick();
        bus.avs_write = 1'b0;
        m_mem[8'h30] = 32'h3030_3030;

        jtag_cmd("a_load10", 3'b100, a_word(8'h10, 1'b0), 2);
        jtag_cmd("b1", 3'b010, b_word(32'hA5A5_0001), 2);
        jtag_cmd("b2", 3'b010, b_word(32'hA5A5_0002), 2);
        jtag_cmd("b3", 3'b010, b_word(32'hA5A5_0003), 2);
        check("areg_13", 32'(mon_a), 32'h13);
        jtag_cmd("a_rd10", 3'b100, a_word(8'h10, 1'b1), 2);
        check("dreg_a5_1", mon_d, 32'hA5A5_0001);
        jtag_cmd("na1", 3'b001, '0, 2);
        check("dreg_a5_2", mon_d, 32'hA5A5_0002);
        jtag_cmd("na2", 3'b001, '0, 2);
        check("dreg_a5_3", mon_d, 32'hA5A5_0003);

        jtag_cmd("a_loadff", 3'b100, a_word(8'hFF, 1'b0), 1);
        jtag_cmd("b_wrap", 3'b010, b_word(32'hDEAD_BEEF), 1);
        check("areg_wrap", 32'(mon_a), 32'h0);
        cpu_write("w00", 8'h00, 32'h0BAD_F00D, 4'hF);
        jtag_cmd("a_loadff2", 3'b100, a_word(8'hFF, 1'b0), 1);
        jtag_cmd("na_wrap", 3'b001, '0, 1);
        check("dreg_wrap", mon_d, 32'h0BAD_F00D);
        cpu_read("rd_ff", 8'hFF, -1, 3'b000, '0, 3, data);
        check("rd_ff_const", data, 32'hDEAD_BEEF);

        cpu_write("w20_clr", 8'h20, 32'h0, 4'hF);
        cpu_write("w20_be", 8'h20, 32'h1122_3344, 4'b0101);
        cpu_read("rd20", 8'h20, -1, 3'b000, '0, 3, data);
        check("rd20_const", data, 32'h0022_0044);

        // JTAG write to the very word the CPU reads, same cycle: JTAG lands first.
        jtag_cmd("a_load20", 3'b100, a_word(8'h20, 1'b0), 1);
        cpu_read("rd20_vs_b", 8'h20, 0, 3'b010, b_word(32'hCAFE_0001), 4, data);
        check("rd20_vs_b_const", data, 32'hCAFE_0001);
        check("areg_after_b", 32'(mon_a), 32'h21);

        cpu_read("rd20_pend", 8'h20, 1, 3'b100, a_word(8'h12, 1'b1), 3, data);
        check("pend_not_yet", 32'(mon_a), 32'h21);
        tick();
        check("pend_areg", 32'(mon_a), 32'h12);
        tick();
        check("pend_dreg", mon_d, 32'hA5A5_0003);

        check("ovf_pre", 32'(ovf), 32'h0);
        jtag_cmd("a_b_same", 3'b110, a_word(8'h55, 1'b0), 2);
        check("ovf_set", 32'(ovf), 32'h1);
        cpu_read("rd12_untouched", 8'h12, -1, 3'b000, '0, 3, data);
        check("rd12_const", data, 32'hA5A5_0003);

        for (int i = 0; i < DEPTH; i++) begin
            cpu_write("fill", ADDR_W'(i), $urandom, 4'hF);
        end
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 4));
            r  = {$urandom, $urandom};
            case (op)
                0: jtag_cmd("rnd_a", 3'b100, r[37:0], int'($urandom_range(0, 2)));
                1: jtag_cmd("rnd_b", 3'b010, r[37:0], int'($urandom_range(0, 2)));
                2: jtag_cmd("rnd_na", 3'b001, r[37:0], int'($urandom_range(0, 2)));
                3: cpu_write("rnd_w", ADDR_W'($urandom), $urandom, 4'($urandom_range(0, 15)));
                default: cpu_read("rnd_r", ADDR_W'($urandom), -1, 3'b000, '0, 3, data);
            endcase
        end
        check("ovf_sticky", 32'(ovf), 32'h1);

        // Reset mid-cycle: control state clears, RAM contents survive.
        #2;
        reset_n = 1'b0;
        #1;
        m_a   = 0;
        m_d   = '0;
        m_ovf = 1'b0;
        check("rst2_ovf", 32'(ovf), 32'h0);
        check("rst2_areg", 32'(mon_a), 32'h0);
        check("rst2_dreg", mon_d, 32'h0);
        check("rst2_rdata", bus.avs_readdata, 32'h0);
        check("rst2_wait", 32'(bus.avs_waitrequest), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        cpu_read("rd_after_rst", 8'h20, -1, 3'b000, '0, 3, data);
        jtag_cmd("na_after_rst", 3'b001, '0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
